// File: rtl/mux_tree_pkg.sv
// mux_tree_pkg: shared constants and elaboration helpers for the radix-4 mux tree.
package mux_tree_pkg;
   localparam logic MODE_EXT  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;
   function automatic int log4(input int n);
      int r = 0;
      for (int v = n; v > 1; v = v / 4) r++;
      return r;
   endfunction
   function automatic bit num_ch_ok(input int n);
      return n >= 4 && n <= 256 && (1 << (2 * log4(n))) == n;
   endfunction
endpackage

// File: rtl/mux4_stage.sv
// mux4_stage: one registered radix-4 tree level; channel group g picks input 4g+idx[2J+1:2J].
module mux4_stage #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int SW = 2,
   parameter int J  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                in_valid,
   input  logic [N*DW-1:0]     in_data,
   input  logic [SW-1:0]       in_idx,
   output logic                out_valid,
   output logic [N/4*DW-1:0]   out_data,
   output logic [SW-1:0]       out_idx
);
   logic [1:0] s;
   assign s = in_idx[2*J +: 2];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_idx   <= in_idx;
         for (int g = 0; g < N / 4; g++)
            out_data[g*DW +: DW] <= in_data[(4*g + int'(s))*DW +: DW];
      end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined radix-4 channel selector with external or auto-scan index.
module mux_tree_pipe import mux_tree_pkg::*; #(
   parameter  int NUM_CH = 16,
   parameter  int DW     = 8,
   localparam int LEVELS = log4(NUM_CH),
   localparam int SW     = 2 * LEVELS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CH*DW-1:0] in,
   input  logic [SW-1:0]        sel,
   input  logic                 mode,
   input  logic                 scan_clr,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DW-1:0]        out,
   output logic [SW-1:0]        out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);
   logic          en;
   logic [SW-1:0] scan_cnt, idx;
   if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
      $error("mux_tree_pipe: NUM_CH must be a power of 4 in 4..256");
   end
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign idx      = (mode == MODE_SCAN) ? scan_cnt : sel;
   // SW bits span exactly NUM_CH values, so the counter wraps on its own
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) scan_cnt <= '0;
      else if (scan_clr) scan_cnt <= '0;
      else if (en && in_valid && mode == MODE_SCAN) scan_cnt <= scan_cnt + 1'b1;
   for (genvar j = 0; j < LEVELS; j++) begin : g_stg
      localparam int NI = NUM_CH >> (2 * j);
      logic [NI*DW-1:0]   d_in;
      logic [NI/4*DW-1:0] d_out;
      logic               v_in, v_out;
      logic [SW-1:0]      i_in, i_out;
      if (j == 0) begin : g_head
         assign d_in = in;
         assign v_in = in_valid;
         assign i_in = idx;
      end else begin : g_link
         assign d_in = g_stg[j-1].d_out;
         assign v_in = g_stg[j-1].v_out;
         assign i_in = g_stg[j-1].i_out;
      end
      mux4_stage #(.N(NI), .DW(DW), .SW(SW), .J(j)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en),
         .in_valid  (v_in),
         .in_data   (d_in),
         .in_idx    (i_in),
         .out_valid (v_out),
         .out_data  (d_out),
         .out_idx   (i_out)
      );
   end
   assign out       = g_stg[LEVELS-1].d_out;
   assign out_ch    = g_stg[LEVELS-1].i_out;
   assign out_valid = g_stg[LEVELS-1].v_out;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: random and directed checks against a queue-based selection model.
module tb_mux_tree_pipe;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] in_bus;
   logic [3:0]   sel, out_ch;
   logic         mode, scan_clr, in_valid, in_ready, out_valid, out_ready;
   logic [7:0]   out;
   typedef struct packed {
      logic [3:0] ch;
      logic [7:0] d;
   } exp_t;
   exp_t       q[$];
   exp_t       e;
   logic [3:0] ch_log[$];
   int         nvec = 0, nerr = 0, nout = 0, n0, k;
   logic [3:0] cnt = '0, ch_m, held_ch;
   logic [7:0] held_d;
   logic       prev_stall = 1'b0;

   always #5 clk = ~clk;

   mux_tree_pipe #(.NUM_CH(16), .DW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_bus),
      .sel       (sel),
      .mode      (mode),
      .scan_clr  (scan_clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pattern();
      for (int i = 0; i < 16; i++) in_bus[i*8 +: 8] = 8'(8'h10 + i);
   endtask

   // Model: a transfer picks channel (mode ? scan counter : sel); outputs emerge in order.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         cnt = '0;
         prev_stall = 1'b0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out", out, 0);
         chk("rst_out_ch", out_ch, 0);
         chk("rst_in_ready", in_ready, 1);
      end else begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_out", out, held_d);
            chk("hold_ch", out_ch, held_ch);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
               e = q.pop_front();
               chk("out", out, e.d);
               chk("out_ch", out_ch, e.ch);
               ch_log.push_back(out_ch);
               nout++;
            end
         end
         prev_stall = out_valid && !out_ready;
         held_d = out;
         held_ch = out_ch;
         if (in_valid && in_ready) begin
            ch_m = mode ? cnt : sel;
            q.push_back('{ch: ch_m, d: in_bus[int'(ch_m)*8 +: 8]});
            if (mode) cnt = cnt + 1'b1;
         end
         if (scan_clr) cnt = '0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      pattern();
      sel = '0; mode = 1'b0; scan_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_in_ready_async", in_ready, 1);
      step(); step();
      rst_n = 1'b1;
      // single external transfer, two-cycle latency, one-cycle pulse
      in_valid = 1'b1; sel = 4'd9;
      step();
      chk("lat1_valid", out_valid, 0);
      in_valid = 1'b0;
      step();
      chk("lat2_valid", out_valid, 1);
      chk("lat2_out", out, 8'h19);
      chk("lat2_ch", out_ch, 9);
      step();
      chk("lat3_valid", out_valid, 0);
      // scan streaming across the wrap
      ch_log.delete();
      n0 = nout;
      mode = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 18; i++) step();
      in_valid = 1'b0;
      step(); step();
      chk("scan_count", nout - n0, 18);
      if (ch_log.size() == 18) begin
         chk("scan_wrap0", ch_log[16], 0);
         chk("scan_wrap1", ch_log[17], 1);
      end
      step(); step();
      // backpressure: out_ready low for 4 cycles mid-stream
      mode = 1'b0;
      n0 = nout;
      k = 0;
      for (int c = 0; c < 30 && k < 6; c++) begin
         in_valid = 1'b1;
         sel = 4'(k);
         out_ready = !(c >= 3 && c < 7);
         @(negedge clk);
         if (in_ready) k++;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_accepted", k, 6);
      for (int i = 0; i < 4; i++) step();
      chk("bp_count", nout - n0, 6);
      // scan_clr coinciding with a scan transfer at count 7
      scan_clr = 1'b1;
      step();
      scan_clr = 1'b0;
      mode = 1'b1;
      in_valid = 1'b1;
      ch_log.delete();
      for (int i = 0; i < 7; i++) step();
      scan_clr = 1'b1;
      step();
      scan_clr = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("clr_len", ch_log.size(), 9);
      if (ch_log.size() == 9) begin
         chk("clr_pre", ch_log[7], 7);
         chk("clr_post", ch_log[8], 0);
      end
      // async reset with two transfers in flight
      in_valid = 1'b1;
      step(); step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      step(); step();
      rst_n = 1'b1;
      n0 = nout;
      for (int i = 0; i < 4; i++) step();
      chk("arst_no_output", nout - n0, 0);
      ch_log.delete();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("arst_scan_zero", ch_log.size() == 1 ? ch_log[0] : 4'hF, 0);
      // mode switch mid-stream; counter frozen while external
      scan_clr = 1'b1;
      step();
      scan_clr = 1'b0;
      ch_log.delete();
      in_valid = 1'b1;
      sel = 4'd3;
      for (int i = 0; i < 10; i++) begin
         mode = (i < 4 || i >= 8);
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("ms_len", ch_log.size(), 10);
      if (ch_log.size() == 10) begin
         chk("ms_inflight", ch_log[3], 3);
         chk("ms_ext", ch_log[5], 3);
         chk("ms_frozen", ch_log[8], 4);
      end
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         in_bus = {$urandom, $urandom, $urandom, $urandom};
         in_valid = ($urandom % 4) != 0;
         sel = 4'($urandom);
         mode = 1'($urandom);
         scan_clr = ($urandom % 16) == 0;
         out_ready = ($urandom % 10) < 7;
         step();
      end
      in_valid = 1'b0;
      scan_clr = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("drain", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 16, meaning the channel count; it SHALL be a power of 4 in the range 4..256.
REQ-002 The module SHALL have parameter DW, default 8, meaning the per-channel data width in bits.
REQ-003 The module SHALL use derived constants LEVELS = log4(NUM_CH) and SW = 2*LEVELS; these are not overridable.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in: input, NUM_CH*DW bits; channel k occupies in[k*DW +: DW].
REQ-007 Port sel: input, SW bits; the channel index used in external mode.
REQ-008 Port mode: input, 1 bit; 0 selects external mode (sel), 1 selects auto-scan mode.
REQ-009 Port scan_clr: input, 1 bit; synchronous clear of the scan counter.
REQ-010 Port in_valid: input, 1 bit; qualifies in, sel and mode.
REQ-011 Port in_ready: output, 1 bit; the pipeline can accept input.
REQ-012 Port out: output, DW bits; the selected channel data.
REQ-013 Port out_ch: output, SW bits; the channel index that produced out.
REQ-014 Port out_valid: output, 1 bit; qualifies out and out_ch.
REQ-015 Port out_ready: input, 1 bit; the downstream can accept output.

Function
REQ-016 The datapath SHALL be a radix-4 tree of LEVELS stages, with each stage output registered.
REQ-017 Stage j SHALL use select bits [2j+1:2j] of the index, carried forward with the data.
REQ-018 Latency SHALL be exactly LEVELS cycles from an accepted input to its out_valid with no stall; for example, NUM_CH=16 gives 2 cycles.
REQ-019 The global enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-020 When en=0, all stage registers, valid bits and the scan counter SHALL hold.
REQ-021 An input transfer SHALL occur when in_valid && in_ready.
REQ-022 A bubble (in_valid=0 while en=1) SHALL propagate as valid=0 through the pipeline.
REQ-023 The effective index SHALL be sel when mode=0 and scan_cnt when mode=1; it travels with the data and emerges as out_ch.
REQ-024 scan_cnt SHALL be SW bits wide.
REQ-025 scan_cnt SHALL increment by 1 on each transfer made with mode=1, and SHALL wrap from NUM_CH-1 to 0.
REQ-026 scan_cnt SHALL hold on transfers made with mode=0.
REQ-027 When scan_clr=1, scan_cnt SHALL go to 0 on that edge, with priority over increment and independent of en.
REQ-028 If scan_clr coincides with a mode=1 transfer, that transfer SHALL use the pre-clear scan_cnt value.
REQ-029 A mode change SHALL take effect on the next transfer; data already in flight SHALL be unaffected.
REQ-030 When out_valid=1 and out_ready=0, out and out_ch SHALL be stable until accepted.
REQ-031 Data registers SHALL not be required to hold defined values while their valid bit is 0.

Reset
REQ-032 On rst_n=0, all stage valid bits, out_valid and scan_cnt SHALL be 0 immediately and asynchronously.
REQ-033 On rst_n=0, out and out_ch SHALL be 0.
REQ-034 During reset, in_ready SHALL read 1.
REQ-035 Reset during operation SHALL discard all in-flight data; no partial output SHALL appear after release.
REQ-036 The first transfer after reset release SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-037 Shared package mux_tree_pkg SHALL hold the log4 constant function, the mode encoding constants (MODE_EXT=0, MODE_SCAN=1) and the NUM_CH legality check.
REQ-038 Sub-module mux4_stage SHALL implement one registered tree level: N/4 parallel 4:1 selects of DW bits plus valid/index pass-through with enable.
REQ-039 mux_tree_pipe SHALL instantiate LEVELS instances of mux4_stage through a generate loop.

Verification (NUM_CH=16, DW=8, channel k input = 8'h10+k)
REQ-040 External mode, out_ready=1: sel=4'd9 with in_valid for 1 cycle -> 2 cycles later out=8'h19, out_ch=9, out_valid for exactly 1 cycle.
REQ-041 Scan mode, streaming in_valid=1 for 18 cycles -> out_ch sequence 0..15,0,1 and out=8'h10..8'h1F,8'h10,8'h11 with no gaps.
REQ-042 Backpressure: stream sel=0..5 while holding out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, out held stable, all six values delivered in order with none lost or duplicated.
REQ-043 scan_clr asserted at scan_cnt=7 together with a mode=1 transfer -> that transfer yields out_ch=7 and the next yields out_ch=0.
REQ-044 rst_n pulsed low with 2 transfers in flight -> out_valid=0 immediately, neither transfer emerges, and scan_cnt=0 after release.
REQ-045 Mode switch 1->0 mid-stream with sel=4'd3 -> in-flight scan results emerge unchanged, subsequent outputs have out_ch=3, and scan_cnt is frozen.
